// File: rtl/load_progress_if.sv
// Handshake between the loader/ioctl logic and the progress-bar overlay.
// The loader side drives the strobes and the progress source returns the overlay inputs.
interface load_progress_if;
  logic        start;
  logic [24:0] size;
  logic        data_wr;
  logic        abort;
  logic [24:0] current;
  logic [24:0] max;
  logic        enable;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    output start, size, data_wr, abort,
    input  current, max, enable, busy, done, timeout
  );

  modport slave (
    input  start, size, data_wr, abort,
    output current, max, enable, busy, done, timeout
  );
endinterface

// File: rtl/load_progress.sv
// Loading-bar progress source: counts unit writes of a bounded transfer and keeps
// the overlay visible for HOLD_CYCLES clocks after completion.
module load_progress #(
  parameter int unsigned HOLD_CYCLES    = 12_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           reset,
  load_progress_if.slave bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST =
    IDLE_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [24:0]         current_q, current_d;
  logic [24:0]         max_q, max_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                start_ok;

  // A zero-size start never opens a transfer; in RUN it cancels like abort.
  assign start_ok = bus.start && (bus.size != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    current_d  = current_q;
    max_d      = max_q;
    hold_cnt_d = hold_cnt_q;
    idle_cnt_d = idle_cnt_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d    = S_RUN;
          current_d  = '0;
          max_d      = bus.size;
          idle_cnt_d = '0;
        end
      end

      S_RUN: begin
        if (start_ok) begin
          current_d  = '0;
          max_d      = bus.size;
          idle_cnt_d = '0;
        end else if (bus.start || bus.abort) begin
          state_d   = S_IDLE;
          current_d = '0;
        end else if (bus.data_wr) begin
          current_d  = current_q + 25'd1;
          idle_cnt_d = '0;
          if (current_q + 25'd1 == max_q) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            done_d     = 1'b1;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (idle_cnt_q == IDLE_LAST) begin
            state_d   = S_IDLE;
            current_d = '0;
            timeout_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (start_ok) begin
          state_d    = S_RUN;
          current_d  = '0;
          max_d      = bus.size;
          idle_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = S_IDLE;
          current_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      current_q  <= '0;
      max_q      <= '0;
      hold_cnt_q <= '0;
      idle_cnt_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      current_q  <= current_d;
      max_q      <= max_d;
      hold_cnt_q <= hold_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.current = current_q;
  assign bus.max     = max_q;
  assign bus.enable  = (state_q != S_IDLE);
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_load_progress.sv
// Directed bench for load_progress: per-clock vector table plus hand-written
// sequences for asynchronous reset and size-1 / full-width transfers.
module tb_load_progress;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  load_progress_if bus ();

  load_progress #(
    .HOLD_CYCLES   (8),
    .TIMEOUT_CYCLES(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [24:0] sz;
    logic        wr;
    logic        ab;
    logic [24:0] cur;
    logic [24:0] mx;
    logic        en;
    logic        bz;
    logic        dn;
    logic        to;
  } vec_t;

  vec_t vecs[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic add(input logic st, input logic [24:0] sz, input logic wr, input logic ab,
                     input logic [24:0] cur, input logic [24:0] mx,
                     input logic en, input logic bz, input logic dn, input logic to);
    vec_t v;
    v.st = st; v.sz = sz; v.wr = wr; v.ab = ab;
    v.cur = cur; v.mx = mx; v.en = en; v.bz = bz; v.dn = dn; v.to = to;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [24:0] cur, input logic [24:0] mx,
                       input logic en, input logic bz, input logic dn, input logic to);
    logic [53:0] act, exp;
    act = {bus.current, bus.max, bus.enable, bus.busy, bus.done, bus.timeout};
    exp = {cur, mx, en, bz, dn, to};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got cur=%0d max=%0d en=%b busy=%b done=%b to=%b, want cur=%0d max=%0d en=%b busy=%b done=%b to=%b",
               name, bus.current, bus.max, bus.enable, bus.busy, bus.done, bus.timeout,
               cur, mx, en, bz, dn, to);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic st, input logic [24:0] sz, input logic wr, input logic ab);
    @(negedge clk);
    bus.start   = st;
    bus.size    = sz;
    bus.data_wr = wr;
    bus.abort   = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.size    = '0;
    bus.data_wr = 1'b0;
    bus.abort   = 1'b0;

    // size 4 transfer, HOLD with ignored write/abort, release 8 edges after the last write
    add(1, 4, 0, 0,  0, 4, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 4, 1, 1, 0, 0);
    add(0, 0, 1, 0,  2, 4, 1, 1, 0, 0);
    add(0, 0, 1, 0,  3, 4, 1, 1, 0, 0);
    add(0, 0, 1, 0,  4, 4, 1, 0, 1, 0);
    add(0, 0, 0, 0,  4, 4, 1, 0, 0, 0);
    add(0, 0, 1, 0,  4, 4, 1, 0, 0, 0);
    add(0, 0, 0, 1,  4, 4, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0,  4, 4, 1, 0, 0, 0);
    add(0, 0, 0, 0,  0, 4, 0, 0, 0, 0);
    // zero-size start and stray write in IDLE
    add(1, 0, 0, 0,  0, 4, 0, 0, 0, 0);
    add(0, 0, 1, 0,  0, 4, 0, 0, 0, 0);
    // restart beats a same-cycle write
    add(1, 10, 0, 0, 0, 10, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 10, 1, 1, 0, 0);
    add(0, 0, 1, 0,  2, 10, 1, 1, 0, 0);
    add(1, 5, 1, 0,  0, 5, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 5, 1, 1, 0, 0);
    // abort beats a same-cycle write, max retained
    add(0, 0, 1, 1,  0, 5, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 5, 0, 0, 0, 0);
    // timeout six edges after the last write
    add(1, 3, 0, 0,  0, 3, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 3, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0,  1, 3, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0, 3, 0, 0, 0, 1);
    add(0, 0, 0, 0,  0, 3, 0, 0, 0, 0);
    // write on the fifth idle clock re-arms the timeout
    add(1, 3, 0, 0,  0, 3, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 3, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0,  1, 3, 1, 1, 0, 0);
    add(0, 0, 1, 0,  2, 3, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0,  2, 3, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0, 3, 0, 0, 0, 1);
    // timeout counted from start with no writes at all
    add(1, 7, 0, 0,  0, 7, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0,  0, 7, 1, 1, 0, 0);
    add(0, 0, 0, 0,  0, 7, 0, 0, 0, 1);
    // start from HOLD re-enters RUN; zero-size start and abort ignored in HOLD
    add(1, 2, 0, 0,  0, 2, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 2, 1, 1, 0, 0);
    add(0, 0, 1, 0,  2, 2, 1, 0, 1, 0);
    add(0, 0, 0, 0,  2, 2, 1, 0, 0, 0);
    add(1, 2, 0, 0,  0, 2, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 2, 1, 1, 0, 0);
    add(0, 0, 1, 0,  2, 2, 1, 0, 1, 0);
    add(0, 0, 0, 0,  2, 2, 1, 0, 0, 0);
    add(1, 0, 0, 0,  2, 2, 1, 0, 0, 0);
    add(0, 0, 0, 1,  2, 2, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0,  2, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0,  0, 2, 0, 0, 0, 0);
    // zero-size start in RUN cancels; start beats abort
    add(1, 6, 0, 0,  0, 6, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 6, 1, 1, 0, 0);
    add(1, 0, 0, 0,  0, 6, 0, 0, 0, 0);
    add(1, 6, 0, 0,  0, 6, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 6, 1, 1, 0, 0);
    add(1, 3, 0, 1,  0, 3, 1, 1, 0, 0);
    add(0, 0, 0, 1,  0, 3, 0, 0, 0, 0);
    // full-width size
    add(1, 25'h1FF_FFFF, 0, 0,  0, 25'h1FF_FFFF, 1, 1, 0, 0);
    add(0, 0, 1, 0,  1, 25'h1FF_FFFF, 1, 1, 0, 0);
    add(0, 0, 0, 1,  0, 25'h1FF_FFFF, 0, 0, 0, 0);

    #1;
    check("reset state", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sz, vecs[i].wr, vecs[i].ab);
      check($sformatf("vec %0d", i), vecs[i].cur, vecs[i].mx, vecs[i].en, vecs[i].bz,
            vecs[i].dn, vecs[i].to);
    end

    // asynchronous reset mid-RUN clears outputs before any clock edge
    drive(1, 9, 0, 0);
    check("rst run start", 0, 9, 1, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("rst run write", 1, 9, 1, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("async reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    // first edge after release samples start; size 1 completes on its first write
    drive(1, 1, 0, 0);
    check("post-reset start", 0, 1, 1, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("size1 done", 1, 1, 1, 0, 1, 0);
    drive(0, 0, 0, 0);
    check("size1 hold", 1, 1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
